iq_dsm_modulator: RTL

//  Dual-channel (I/Q) 2nd-order single-bit delta-sigma modulator feeding upconverter.data_i/data_q.

---
 rtl/iq_dsm_modulator_if.sv | 16 +
 rtl/iq_dsm_modulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_dsm_modulator_if.sv
// Sample handshake between a baseband source and iq_dsm_modulator.
//   i_data / q_data : signed I and Q samples (DATA_W bits)
//   valid           : source offers a sample this cycle
//   ready           : modulator accepts it (transfer = valid & ready)
// master = sample source, slave = modulator.
interface iq_dsm_modulator_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] i_data;
  logic signed [DATA_W-1:0] q_data;
  logic                     valid;
  logic                     ready;

  modport master (output i_data, output q_data, output valid, input ready);
  modport slave  (input i_data, input q_data, input valid, output ready);
endinterface

// File: rtl/iq_dsm_modulator.sv
// Dual-channel (I/Q) second-order single-bit delta-sigma modulator.
// Each accepted sample is held for OSR clocks (zero-order hold) while the
// loops emit one I and one Q bit per clock. A one-entry pending buffer sits
// in front of the active sample; if it is empty when a hold period ends the
// active sample is repeated and underrun_o pulses.
//
// Ports
//   clk_i       bit-rate clock
//   rst_i       synchronous reset, active high
//   enable_i    1 = run, 0 = return to IDLE and clear loop state
//   s_if        slave side of the sample handshake
//   data_i_o    I bitstream (1 = +FS, 0 = -FS)
//   data_q_o    Q bitstream
//   underrun_o  one-cycle pulse, in the cycle after a hold period ended
//               with no sample available
//   running_o   high while in RUN
//
// state | meaning
// IDLE  | integrators at 0, both outputs toggle (mid-scale)
// PRIME | outputs toggle, waiting for the first sample
// RUN   | loops active, samples held for OSR clocks each
module iq_dsm_modulator #(
  parameter int DATA_W = 16,
  parameter int OSR    = 64,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  iq_dsm_modulator_if.slave s_if,
  output logic              data_i_o,
  output logic              data_q_o,
  output logic              underrun_o,
  output logic              running_o
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  // Two guard bits cover integrator + sample + feedback before clamping.
  localparam int SUM_W = ACC_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic signed [SUM_W-1:0] FS_EXT =
    {{(SUM_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO = {3'b111, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         osr_cnt_q, osr_cnt_d;
  logic signed [DATA_W-1:0] act_i_q, act_i_d, act_q_q, act_q_d;
  logic signed [DATA_W-1:0] pend_i_q, pend_i_d, pend_q_q, pend_q_d;
  logic                     pend_full_q, pend_full_d;
  logic signed [ACC_W-1:0]  int1_i_q, int1_i_d, int2_i_q, int2_i_d;
  logic signed [ACC_W-1:0]  int1_q_q, int1_q_d, int2_q_q, int2_q_d;
  logic                     bit_i_q, bit_i_d, bit_q_q, bit_q_d;
  logic                     underrun_q, underrun_d;

  logic                     ready;
  logic                     hs;
  logic                     boundary;
  logic signed [ACC_W-1:0]  nxt1_i, nxt2_i, nxt1_q, nxt2_q;
  logic                     nxtb_i, nxtb_q;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[ACC_W-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[ACC_W-1:0];
    end
    return v[ACC_W-1:0];
  endfunction

  // One loop iteration for a single channel.
  function automatic void dsm_step(
    input  logic signed [ACC_W-1:0]  int1,
    input  logic signed [ACC_W-1:0]  int2,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     b,
    output logic signed [ACC_W-1:0]  int1_n,
    output logic signed [ACC_W-1:0]  int2_n,
    output logic                     b_n
  );
    logic signed [SUM_W-1:0] fb;
    logic signed [SUM_W-1:0] x_ext;
    logic signed [SUM_W-1:0] int1_ext;
    logic signed [SUM_W-1:0] int2_ext;
    logic signed [SUM_W-1:0] n1_ext;
    fb       = b ? FS_EXT : -FS_EXT;
    x_ext    = {{(SUM_W-DATA_W){x[DATA_W-1]}}, x};
    int1_ext = {{2{int1[ACC_W-1]}}, int1};
    int2_ext = {{2{int2[ACC_W-1]}}, int2};
    int1_n   = sat(int1_ext + x_ext - fb);
    n1_ext   = {{2{int1_n[ACC_W-1]}}, int1_n};
    int2_n   = sat(int2_ext + n1_ext - fb);
    b_n      = ~int2_n[ACC_W-1];
  endfunction

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (hs) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    ready     = (state_q != ST_IDLE) && !pend_full_q;
    running_o = (state_q == ST_RUN);
  end

  assign s_if.ready = ready;
  assign hs         = s_if.valid & ready;
  assign boundary   = (state_q == ST_RUN) && (osr_cnt_q == CNT_LAST);

  always_comb begin
    nxt1_i = '0;
    nxt2_i = '0;
    nxtb_i = 1'b0;
    nxt1_q = '0;
    nxt2_q = '0;
    nxtb_q = 1'b0;
    dsm_step(int1_i_q, int2_i_q, act_i_q, bit_i_q, nxt1_i, nxt2_i, nxtb_i);
    dsm_step(int1_q_q, int2_q_q, act_q_q, bit_q_q, nxt1_q, nxt2_q, nxtb_q);
  end

  always_comb begin
    osr_cnt_d   = osr_cnt_q;
    act_i_d     = act_i_q;
    act_q_d     = act_q_q;
    pend_i_d    = pend_i_q;
    pend_q_d    = pend_q_q;
    pend_full_d = pend_full_q;
    int1_i_d    = int1_i_q;
    int2_i_d    = int2_i_q;
    int1_q_d    = int1_q_q;
    int2_q_d    = int2_q_q;
    bit_i_d     = bit_i_q;
    bit_q_d     = bit_q_q;
    underrun_d  = 1'b0;

    if (!enable_i || state_q != ST_RUN) begin
      // Outside RUN the loops rest at zero and the outputs sit at mid-scale.
      int1_i_d = '0;
      int2_i_d = '0;
      int1_q_d = '0;
      int2_q_d = '0;
      bit_i_d  = ~bit_i_q;
      bit_q_d  = ~bit_q_q;
    end

    if (!enable_i) begin
      // A transfer offered in this cycle is dropped along with the buffer.
      osr_cnt_d   = '0;
      pend_i_d    = '0;
      pend_q_d    = '0;
      pend_full_d = 1'b0;
    end else if (state_q == ST_PRIME) begin
      if (hs) begin
        act_i_d   = s_if.i_data;
        act_q_d   = s_if.q_data;
        osr_cnt_d = '0;
      end
    end else if (state_q == ST_RUN) begin
      int1_i_d  = nxt1_i;
      int2_i_d  = nxt2_i;
      bit_i_d   = nxtb_i;
      int1_q_d  = nxt1_q;
      int2_q_d  = nxt2_q;
      bit_q_d   = nxtb_q;
      osr_cnt_d = boundary ? '0 : osr_cnt_q + 1'b1;
      if (boundary) begin
        if (pend_full_q) begin
          act_i_d     = pend_i_q;
          act_q_d     = pend_q_q;
          pend_full_d = 1'b0;
        end else if (hs) begin
          // Arrives just in time: skip the buffer.
          act_i_d = s_if.i_data;
          act_q_d = s_if.q_data;
        end else begin
          underrun_d = 1'b1;
        end
      end else if (hs) begin
        pend_i_d    = s_if.i_data;
        pend_q_d    = s_if.q_data;
        pend_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      osr_cnt_q   <= '0;
      act_i_q     <= '0;
      act_q_q     <= '0;
      pend_i_q    <= '0;
      pend_q_q    <= '0;
      pend_full_q <= 1'b0;
      int1_i_q    <= '0;
      int2_i_q    <= '0;
      int1_q_q    <= '0;
      int2_q_q    <= '0;
      bit_i_q     <= 1'b0;
      bit_q_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      osr_cnt_q   <= osr_cnt_d;
      act_i_q     <= act_i_d;
      act_q_q     <= act_q_d;
      pend_i_q    <= pend_i_d;
      pend_q_q    <= pend_q_d;
      pend_full_q <= pend_full_d;
      int1_i_q    <= int1_i_d;
      int2_i_q    <= int2_i_d;
      int1_q_q    <= int1_q_d;
      int2_q_q    <= int2_q_d;
      bit_i_q     <= bit_i_d;
      bit_q_q     <= bit_q_d;
      underrun_q  <= underrun_d;
    end
  end

  assign data_i_o   = bit_i_q;
  assign data_q_o   = bit_q_q;
  assign underrun_o = underrun_q;

endmodule
